// File: rtl/trigger_link_pkg.sv
// Shared constants for the trigger link framer: comma/idle characters, frame geometry
// and link bring-up state encodings.
package trigger_link_pkg;

    localparam int FRAME_BITS      = 64;
    localparam int COMMA_BITS      = 8;
    localparam int PAYLOAD_BITS    = FRAME_BITS - COMMA_BITS;
    localparam int WORD_BITS       = 16;
    localparam int ADDR_BITS       = 11;

    localparam logic [7:0]  K28_5     = 8'hBC;
    localparam logic [7:0]  K28_1     = 8'h3C;
    localparam logic [7:0]  K28_2     = 8'h5C;
    localparam logic [15:0] IDLE_WORD = 16'h50BC;

    localparam logic [1:0] CHARISK_COMMA = 2'b01;
    localparam logic [1:0] CHARISK_DATA  = 2'b00;

    typedef enum logic [1:0] {
        LS_RESET      = 2'd0,
        LS_WAIT_READY = 2'd1,
        LS_SYNC       = 2'd2,
        LS_RUN        = 2'd3
    } link_state_e;

    // BC0 outranks overflow; a plain crossing gets the standard K28.5 comma.
    function automatic logic [COMMA_BITS-1:0] comma_for(input logic bx0, input logic ovf);
        logic [COMMA_BITS-1:0] c;
        c = K28_5;
        if (ovf) c = K28_2;
        if (bx0) c = K28_1;
        return c;
    endfunction

endpackage

// File: rtl/trigger_link_framer_if.sv
// GTX-facing bundle: per-link TX word, K-character flags and the per-link ready status.
// master = framer side, slave = transceiver wrapper side.
interface trigger_link_framer_if
    import trigger_link_pkg::*;
#(
    parameter int NUM_LINKS = 4
);
    logic [NUM_LINKS*WORD_BITS-1:0] tx_data;
    logic [NUM_LINKS*2-1:0]         tx_charisk;
    logic [NUM_LINKS-1:0]           tx_ready;

    modport master (output tx_data, output tx_charisk, input tx_ready);
    modport slave  (input tx_data, input tx_charisk, output tx_ready);
endinterface

// File: rtl/trigger_link_word_mux.sv
// Per-link word selector: picks 16-bit word frame_cnt of the 64-bit frame, or the idle word.
// Purely combinational; no backpressure (GTX consumes one word every cycle).
module trigger_link_word_mux
    import trigger_link_pkg::*;
(
    input  logic [FRAME_BITS-1:0] frame_i,
    input  logic [1:0]            frame_cnt_i,
    input  logic                  frame_live_i,
    input  link_state_e           state_i,
    output logic [WORD_BITS-1:0]  word_o,
    output logic [1:0]            charisk_o
);

    always_comb begin
        word_o    = IDLE_WORD;
        charisk_o = CHARISK_COMMA;
        if (state_i == LS_RUN && frame_live_i) begin
            word_o    = frame_i[{frame_cnt_i, 4'b0000} +: WORD_BITS];
            charisk_o = (frame_cnt_i == 2'd0) ? CHARISK_COMMA : CHARISK_DATA;
        end
    end

endmodule

// File: rtl/trigger_link_framer.sv
// Captures cluster groups per BX and frames them into 4x16-bit comma-led words per fiber; word 0
// one cycle after bx_strobe, no backpressure. Optional macro TRIG_LINK_PRBS_EN adds a PRBS-7 payload.
module trigger_link_framer
    import trigger_link_pkg::*;
#(
    parameter int                   NUM_LINKS         = 4,
    parameter int                   NUM_SOURCES       = 2,
    parameter int                   CLUSTERS_PER_LINK = 4,
    parameter int                   CLUSTER_BITS      = 14,
    parameter logic [ADDR_BITS-1:0] INVALID_ADDR_MIN  = 11'h600,
    parameter int                   SYNC_BX           = 64
) (
    input  logic                                                clk_160,
    input  logic                                                reset_i,
    input  logic                                                bx_strobe,
    input  logic                                                ttc_bx0,
    input  logic                                                overflow,
    input  logic [NUM_SOURCES*CLUSTERS_PER_LINK*CLUSTER_BITS-1:0] clusters,
`ifdef TRIG_LINK_PRBS_EN
    input  logic                                                prbs_en,
`endif
    trigger_link_framer_if.master                               tx,
    output logic [NUM_SOURCES*CLUSTERS_PER_LINK-1:0]            valid_clusters,
    output logic                                                valid_clusters_or,
    output logic [1:0]                                          link_state,
    output logic                                                strobe_err
);

    localparam int NUM_CL     = NUM_SOURCES * CLUSTERS_PER_LINK;
    localparam int GROUP_BITS = CLUSTERS_PER_LINK * CLUSTER_BITS;
    localparam int BUS_BITS   = NUM_CL * CLUSTER_BITS;
    localparam int SYNC_W     = $clog2(SYNC_BX + 1);

    if (GROUP_BITS > PAYLOAD_BITS) begin : g_bad_payload
        $error("CLUSTERS_PER_LINK*CLUSTER_BITS exceeds the 56-bit frame payload");
    end
    if (CLUSTER_BITS < ADDR_BITS) begin : g_bad_cluster
        $error("CLUSTER_BITS too small to hold the 11-bit address field");
    end

    link_state_e          state_q, state_d;
    logic [SYNC_W-1:0]    sync_cnt_q, sync_cnt_d;
    logic [1:0]           frame_cnt_q, frame_cnt_d;
    logic                 frame_live_q, frame_live_d;
    logic                 strobe_err_q, strobe_err_d;
    logic [BUS_BITS-1:0]  clusters_q, clusters_d;
    logic                 bx0_q, bx0_d;
    logic                 ovf_q, ovf_d;
    logic [NUM_CL-1:0]    valid_q, valid_d;
    logic                 valid_or_q, valid_or_d;
    logic [NUM_CL-1:0]    valid_in;
    logic                 all_ready;

    assign all_ready = &tx.tx_ready;

    // Link bring-up; losing any ready bit outranks every other transition.
    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        case (state_q)
            LS_RESET: state_d = LS_WAIT_READY;
            LS_WAIT_READY: begin
                if (bx_strobe && all_ready) begin
                    state_d    = LS_SYNC;
                    sync_cnt_d = '0;
                end
            end
            LS_SYNC: begin
                if (bx_strobe) begin
                    if (sync_cnt_q == SYNC_W'(SYNC_BX - 1)) begin
                        state_d    = LS_RUN;
                        sync_cnt_d = '0;
                    end else begin
                        sync_cnt_d = sync_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = state_q;
        endcase
        if (state_q != LS_RESET && !all_ready) begin
            state_d    = LS_WAIT_READY;
            sync_cnt_d = '0;
        end
    end

    // frame_live distinguishes "showing word 3" from "parked at 3 after the frame ended".
    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        frame_live_d = frame_live_q;
        strobe_err_d = strobe_err_q;
        if (bx_strobe) begin
            frame_cnt_d  = 2'd0;
            frame_live_d = 1'b1;
            if (frame_cnt_q != 2'd3) strobe_err_d = 1'b1;
        end else if (frame_cnt_q != 2'd3) begin
            frame_cnt_d = frame_cnt_q + 2'd1;
        end else if (frame_live_q) begin
            frame_live_d = 1'b0;
            strobe_err_d = 1'b1;
        end
    end

    always_comb begin
        valid_in = '0;
        for (int k = 0; k < NUM_CL; k++) begin
            valid_in[k] = clusters[k*CLUSTER_BITS +: ADDR_BITS] < INVALID_ADDR_MIN;
        end
    end

    always_comb begin
        clusters_d = clusters_q;
        bx0_d      = bx0_q;
        ovf_d      = ovf_q;
        valid_d    = valid_q;
        valid_or_d = valid_or_q;
        if (bx_strobe) begin
            clusters_d = clusters;
            bx0_d      = ttc_bx0;
            ovf_d      = overflow;
            valid_d    = valid_in;
            valid_or_d = |valid_in;
        end
    end

    always_ff @(posedge clk_160) begin
        if (reset_i) begin
            state_q      <= LS_RESET;
            sync_cnt_q   <= '0;
            frame_cnt_q  <= 2'd3;
            frame_live_q <= 1'b0;
            strobe_err_q <= 1'b0;
            clusters_q   <= '0;
            bx0_q        <= 1'b0;
            ovf_q        <= 1'b0;
            valid_q      <= '0;
            valid_or_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_cnt_q   <= sync_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_live_q <= frame_live_d;
            strobe_err_q <= strobe_err_d;
            clusters_q   <= clusters_d;
            bx0_q        <= bx0_d;
            ovf_q        <= ovf_d;
            valid_q      <= valid_d;
            valid_or_q   <= valid_or_d;
        end
    end

`ifdef TRIG_LINK_PRBS_EN
    // PRBS-7 runs on every strobe regardless of prbs_en, one byte per payload lane.
    logic [6:0]              prbs_q, prbs_d;
    logic [PAYLOAD_BITS-1:0] prbs_payload_q, prbs_payload_d;

    always_comb begin
        logic [6:0]              lfsr;
        logic                    fb;
        logic [PAYLOAD_BITS-1:0] bits;
        lfsr           = prbs_q;
        fb             = 1'b0;
        bits           = '0;
        prbs_d         = prbs_q;
        prbs_payload_d = prbs_payload_q;
        for (int b = 0; b < PAYLOAD_BITS; b++) begin
            fb      = lfsr[6] ^ lfsr[5];
            lfsr    = {lfsr[5:0], fb};
            bits[b] = fb;
        end
        if (bx_strobe) begin
            prbs_d         = lfsr;
            prbs_payload_d = bits;
        end
    end

    always_ff @(posedge clk_160) begin
        if (reset_i) begin
            prbs_q         <= 7'h7F;
            prbs_payload_q <= '0;
        end else begin
            prbs_q         <= prbs_d;
            prbs_payload_q <= prbs_payload_d;
        end
    end
`endif

    logic [COMMA_BITS-1:0] comma;
    logic [FRAME_BITS-1:0] frame [NUM_SOURCES];

    assign comma = comma_for(bx0_q, ovf_q);

    always_comb begin
        for (int g = 0; g < NUM_SOURCES; g++) begin
            frame[g] = {PAYLOAD_BITS'(clusters_q[g*GROUP_BITS +: GROUP_BITS]), comma};
`ifdef TRIG_LINK_PRBS_EN
            if (prbs_en && state_q == LS_RUN) frame[g] = {prbs_payload_q, comma};
`endif
        end
    end

    logic [NUM_LINKS*WORD_BITS-1:0] word_bus;
    logic [NUM_LINKS*2-1:0]         charisk_bus;

    for (genvar i = 0; i < NUM_LINKS; i++) begin : g_link
        trigger_link_word_mux u_word_mux (
            .frame_i      (frame[i % NUM_SOURCES]),
            .frame_cnt_i  (frame_cnt_q),
            .frame_live_i (frame_live_q),
            .state_i      (state_q),
            .word_o       (word_bus[i*WORD_BITS +: WORD_BITS]),
            .charisk_o    (charisk_bus[i*2 +: 2])
        );
    end

    assign tx.tx_data          = word_bus;
    assign tx.tx_charisk       = charisk_bus;
    assign valid_clusters      = valid_q;
    assign valid_clusters_or   = valid_or_q;
    assign link_state          = state_q;
    assign strobe_err          = strobe_err_q;

endmodule

// File: tb/tb_trigger_link_framer.sv
// Randomized bench for trigger_link_framer against a per-BX behavioural model
// (frames built by arithmetic, word index = cycles since the last strobe).
module tb_trigger_link_framer;
    import trigger_link_pkg::*;

    localparam int NL = 4, NS = 2, CPL = 4, CB = 14, SYNC = 64;

    logic clk_160 = 1'b0;
    always #5 clk_160 = ~clk_160;

    logic                  reset_i, bx_strobe, ttc_bx0, overflow;
    logic [NS*CPL*CB-1:0]  clusters;
    logic [NS*CPL-1:0]     valid_clusters;
    logic                  valid_clusters_or;
    logic [1:0]            link_state;
    logic                  strobe_err;

    trigger_link_framer_if #(.NUM_LINKS(NL)) tx_if ();

    trigger_link_framer dut (
        .clk_160           (clk_160),
        .reset_i           (reset_i),
        .bx_strobe         (bx_strobe),
        .ttc_bx0           (ttc_bx0),
        .overflow          (overflow),
        .clusters          (clusters),
        .tx                (tx_if.master),
        .valid_clusters    (valid_clusters),
        .valid_clusters_or (valid_clusters_or),
        .link_state        (link_state),
        .strobe_err        (strobe_err)
    );

    logic [CB-1:0] cl [NS][CPL];
    int n_checks = 0;
    int n_errors = 0;

    // Reference state: BX-level view of the link.
    int              m_state, m_sync, m_since;
    bit              m_err, m_vor;
    logic [63:0]     m_frame [NS];
    logic [NS*CPL-1:0] m_valid;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit          all_rdy;
        logic [63:0] pl;
        logic [7:0]  cm;
        if (reset_i) begin
            m_state = 0; m_sync = 0; m_since = -1; m_err = 0; m_valid = '0; m_vor = 0;
            return;
        end
        all_rdy = (tx_if.tx_ready == 4'hF);
        if (m_state == 0) m_state = 1;
        else if (!all_rdy) begin m_state = 1; m_sync = 0; end
        else if (m_state == 1 && bx_strobe) begin m_state = 2; m_sync = 0; end
        else if (m_state == 2 && bx_strobe) begin
            m_sync++;
            if (m_sync == SYNC) m_state = 3;
        end
        if (bx_strobe) begin
            if (m_since >= 0 && m_since < 3) m_err = 1;
            m_since = 0;
            cm = ttc_bx0 ? 8'h3C : (overflow ? 8'h5C : 8'hBC);
            for (int g = 0; g < NS; g++) begin
                pl = 64'd0;
                for (int c = 0; c < CPL; c++) pl = pl + (64'(cl[g][c]) << (CB * c));
                m_frame[g] = (pl << 8) | 64'(cm);
            end
            for (int k = 0; k < NS*CPL; k++) m_valid[k] = (cl[k/CPL][k%CPL][10:0] < 11'h600);
            m_vor = |m_valid;
        end else if (m_since >= 0 && m_since < 4) begin
            m_since++;
            if (m_since == 4) m_err = 1;
        end
    endtask

    task automatic compare_all();
        logic [15:0] w;
        logic [1:0]  k;
        check_val("link_state", 64'(link_state), 64'(m_state));
        check_val("strobe_err", 64'(strobe_err), 64'(m_err));
        check_val("valid_clusters", 64'(valid_clusters), 64'(m_valid));
        check_val("valid_or", 64'(valid_clusters_or), 64'(m_vor));
        for (int i = 0; i < NL; i++) begin
            if (m_state == 3 && m_since >= 0 && m_since <= 3) begin
                w = 16'(m_frame[i % NS] >> (16 * m_since));
                k = (m_since == 0) ? 2'b01 : 2'b00;
            end else begin
                w = 16'h50BC;
                k = 2'b01;
            end
            check_val($sformatf("tx_data%0d", i), 64'(tx_if.tx_data[i*16 +: 16]), 64'(w));
            check_val($sformatf("tx_charisk%0d", i), 64'(tx_if.tx_charisk[i*2 +: 2]), 64'(k));
        end
    endtask

    task automatic tick();
        for (int g = 0; g < NS; g++)
            for (int c = 0; c < CPL; c++) clusters[(g*CPL + c)*CB +: CB] = cl[g][c];
        model_step();
        @(negedge clk_160);
        compare_all();
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe_tick();
        bx_strobe = 1'b1;
        tick();
        bx_strobe = 1'b0;
    endtask

    task automatic rand_clusters();
        logic [10:0] a;
        logic [2:0]  u;
        for (int g = 0; g < NS; g++)
            for (int c = 0; c < CPL; c++) begin
                case ($urandom_range(0, 7))
                    0:       a = 11'h600;
                    1:       a = 11'h5FF;
                    2:       a = 11'h7FF;
                    3:       a = 11'h000;
                    default: a = 11'($urandom_range(0, 2047));
                endcase
                u = 3'($urandom_range(0, 7));
                cl[g][c] = {u, a};
            end
    endtask

    task automatic run_bx(input int n, input bit jitter);
        int period, r;
        for (int b = 0; b < n; b++) begin
            rand_clusters();
            ttc_bx0  = ($urandom_range(0, 15) == 0);
            overflow = ($urandom_range(0, 7) == 0);
            period = 4;
            if (jitter) begin
                r = $urandom_range(0, 9);
                period = (r == 0) ? 3 : (r == 1) ? 5 : (r == 2) ? 7 : 4;
            end
            strobe_tick();
            idle_ticks(period - 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1; bx_strobe = 1'b0; ttc_bx0 = 1'b0; overflow = 1'b0;
        tx_if.tx_ready = 4'hF;
        rand_clusters();
        idle_ticks(3);
        check_val("rst_state", 64'(link_state), 64'd0);
        check_val("rst_data", 64'(tx_if.tx_data), 64'h50BC50BC50BC50BC);
        check_val("rst_charisk", 64'(tx_if.tx_charisk), 64'h55);
        check_val("rst_valid", 64'(valid_clusters), 64'd0);
        reset_i = 1'b0;

        // Bring-up: first strobe lands in RESET, second enters SYNC, 64 more reach RUN.
        run_bx(2, 0);
        check_val("sync_entered", 64'(link_state), 64'd2);
        run_bx(63, 0);
        check_val("sync_63", 64'(link_state), 64'd2);
        run_bx(1, 0);
        check_val("run_entered", 64'(link_state), 64'd3);

        // Directed frame on group 0.
        cl[0][3] = 14'h0001; cl[0][2] = 14'h0002; cl[0][1] = 14'h0003; cl[0][0] = 14'h0004;
        ttc_bx0 = 1'b0; overflow = 1'b0;
        strobe_tick();
        check_val("l0_w0", 64'(tx_if.tx_data[15:0]), 64'h04BC);
        check_val("l2_w0", 64'(tx_if.tx_data[47:32]), 64'h04BC);
        check_val("l0_k0", 64'(tx_if.tx_charisk[1:0]), 64'h1);
        tick();
        check_val("l0_w1", 64'(tx_if.tx_data[15:0]), 64'h00C0);
        check_val("l0_k1", 64'(tx_if.tx_charisk[1:0]), 64'h0);
        tick();
        check_val("l0_w2", 64'(tx_if.tx_data[15:0]), 64'h0020);
        tick();
        check_val("l0_w3", 64'(tx_if.tx_data[15:0]), 64'h0004);
        check_val("l2_w3", 64'(tx_if.tx_data[47:32]), 64'h0004);

        // Comma priority.
        ttc_bx0 = 1'b1; overflow = 1'b1;
        strobe_tick();
        check_val("comma_bc0", 64'(tx_if.tx_data[7:0]), 64'h3C);
        idle_ticks(3);
        ttc_bx0 = 1'b0; overflow = 1'b1;
        strobe_tick();
        check_val("comma_ovf", 64'(tx_if.tx_data[7:0]), 64'h5C);
        idle_ticks(3);

        // Address validity boundary.
        overflow = 1'b0;
        for (int g = 0; g < NS; g++) for (int c = 0; c < CPL; c++) cl[g][c] = 14'h0600;
        strobe_tick();
        check_val("all_invalid", 64'(valid_clusters), 64'd0);
        check_val("all_invalid_or", 64'(valid_clusters_or), 64'd0);
        idle_ticks(3);
        cl[1][2] = 14'h05FF;
        strobe_tick();
        check_val("one_valid", 64'(valid_clusters), 64'h40);
        check_val("one_valid_or", 64'(valid_clusters_or), 64'd1);
        idle_ticks(3);

        run_bx(10, 0);
        check_val("err_clean", 64'(strobe_err), 64'd0);

        // Early strobe at frame_cnt = 1.
        strobe_tick();
        tick();
        ttc_bx0 = 1'b0; overflow = 1'b1;
        rand_clusters();
        strobe_tick();
        check_val("early_err", 64'(strobe_err), 64'd1);
        check_val("early_w0", 64'(tx_if.tx_data[7:0]), 64'h5C);
        check_val("early_k0", 64'(tx_if.tx_charisk[1:0]), 64'h1);
        idle_ticks(3);
        run_bx(4, 0);

        // Reset mid-frame.
        strobe_tick();
        tick();
        reset_i = 1'b1;
        tick();
        check_val("midrst_data", 64'(tx_if.tx_data), 64'h50BC50BC50BC50BC);
        check_val("midrst_err", 64'(strobe_err), 64'd0);
        idle_ticks(2);
        reset_i = 1'b0;
        run_bx(66, 0);
        check_val("rerun", 64'(link_state), 64'd3);

        // Missing strobe after word 3.
        strobe_tick();
        idle_ticks(3);
        tick();
        check_val("miss_err", 64'(strobe_err), 64'd1);
        check_val("miss_idle", 64'(tx_if.tx_data[15:0]), 64'h50BC);
        idle_ticks(4);
        run_bx(3, 0);
        check_val("err_sticky", 64'(strobe_err), 64'd1);

        // Link loss and recovery.
        tx_if.tx_ready = 4'b1011;
        tick();
        check_val("loss_state", 64'(link_state), 64'd1);
        check_val("loss_idle", 64'(tx_if.tx_data), 64'h50BC50BC50BC50BC);
        idle_ticks(2);
        run_bx(2, 0);
        tx_if.tx_ready = 4'hF;
        run_bx(2, 0);
        check_val("resync", 64'(link_state), 64'd2);
        run_bx(62, 0);
        check_val("resync_62", 64'(link_state), 64'd2);
        run_bx(1, 0);
        check_val("rerun2", 64'(link_state), 64'd3);

        run_bx(60, 1);
        run_bx(10, 0);

        reset_i = 1'b1;
        tick();
        check_val("err_cleared", 64'(strobe_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/trigger_link_framer.md
Name: trigger_link_framer

Overview:
Parametrised successor to the fixed four-fiber trigger link block. It captures cluster groups once per bunch crossing (BX) and frames them into 16-bit 8b/10b words with a comma marker, for NUM_LINKS GTX transmitters running at 160 MHz.
It adds:
- a link bring-up state machine (ready wait, idle sync, run);
- BC0 and overflow comma signalling;
- strobe-alignment error detection.
It sits between the cluster packer and the per-fiber GTX wrappers.

Parameters:
NUM_LINKS, 4, number of output fibers.
NUM_SOURCES, 2, number of distinct cluster groups. Link i carries group i % NUM_SOURCES.
CLUSTERS_PER_LINK, 4, clusters per group. CLUSTERS_PER_LINK*CLUSTER_BITS must be ≤56 (elaboration-time check).
CLUSTER_BITS, 14, bits per cluster. The address field is bits [10:0].
INVALID_ADDR_MIN, 11'h600, a cluster address ≥ this value marks the cluster invalid.
SYNC_BX, 64, number of idle BX frames sent after ready, before RUN.

Ports:
clk_160  in  1  160 MHz clock. The single clock domain.
reset_i  in  1  synchronous reset, active-high.
bx_strobe  in  1  one-cycle pulse once per BX (nominally every 4th cycle).
ttc_bx0  in  1  BC0 flag, sampled on bx_strobe.
overflow  in  1  cluster overflow flag, sampled on bx_strobe.
clusters  in  NUM_SOURCES*CLUSTERS_PER_LINK*CLUSTER_BITS  flat bus; group g, cluster c at offset (g*CLUSTERS_PER_LINK+c)*CLUSTER_BITS.
tx_ready  in  NUM_LINKS  per-link (pll_locked & reset_done).
tx_data  out  NUM_LINKS*16  per-link TX word.
tx_charisk  out  NUM_LINKS*2  per-link K-character flags.
valid_clusters  out  NUM_SOURCES*CLUSTERS_PER_LINK  per-cluster valid bits of the last captured BX.
valid_clusters_or  out  1  OR of valid_clusters.
link_state  out  2  0=RESET, 1=WAIT_READY, 2=SYNC, 3=RUN.
strobe_err  out  1  sticky bx_strobe misalignment flag.

Behaviour:
- Reset values:
  - tx_data = idle word 16'h50BC per link; tx_charisk = 2'b01 per link.
  - valid_clusters = 0, valid_clusters_or = 0, strobe_err = 0.
  - link_state = RESET; frame_cnt = 3; sync counter = 0.
- State machine:
  - RESET → WAIT_READY on the first cycle after reset_i deasserts.
  - WAIT_READY → SYNC when &tx_ready is high at a bx_strobe.
  - SYNC → RUN after SYNC_BX bx_strobes counted in SYNC.
  - In any state other than RESET, tx_ready not all-high drops the block immediately to WAIT_READY (checked from the same cycle). Idle words are sent from the next cycle and the sync counter is cleared.
- Capture:
  - On bx_strobe, register clusters, ttc_bx0 and overflow in every state.
  - valid_clusters[k] = (address < INVALID_ADDR_MIN), updated the cycle after the strobe; valid_clusters_or is registered in the same cycle.
- Frame:
  - F[63:0] = {payload zero-padded to 56 bits, comma}.
  - comma = 8'h3C (K28.1) if bx0; else 8'h5C (K28.2) if overflow; else 8'hBC (K28.5). BC0 has priority over overflow.
  - Word k = F[16k+15:16k]. charisk = 2'b01 for word 0, 2'b00 for words 1-3.
- Timing:
  - bx_strobe resets frame_cnt to 0. Word 0 appears on tx_data the cycle after the strobe; words 1, 2, 3 follow on consecutive cycles. Latency is 1 cycle from strobe to first word.
- Non-RUN states: every word is idle (16'h50BC, charisk 01). frame_cnt still advances.
- Boundary conditions:
  - bx_strobe while frame_cnt≠3 (early): restart the frame at word 0 with the new data and set strobe_err.
  - No strobe after word 3: emit idle words until the next strobe; frame_cnt holds at 3; set strobe_err.
  - strobe_err clears only on reset_i.
  - reset_i asserted mid-frame: outputs go to idle on the next cycle.

Optional Feature:
TRIG_LINK_PRBS_EN:
- Defined: adds input prbs_en (1 bit). In RUN with prbs_en high, payload bytes are replaced by a free-running PRBS-7 (x^7+x^6+1, seed 7'h7F on reset), advancing one byte per byte lane. The comma byte is unchanged.
- Undefined: the port and logic are absent and the payload is always cluster data.

Decomposition:
Shared package trigger_link_pkg holds:
- comma/idle constants (K28_5, K28_1, K28_2, IDLE_WORD);
- link_state encodings;
- the frame width constant 64.
One sub-module, trigger_link_word_mux, is per-link: it takes frame + frame_cnt + state and produces the word and charisk. It is instantiated NUM_LINKS times in a generate loop.

Test Plan:
- Bring-up: tx_ready=4'hF, strobe every 4 cycles → link_state goes 1→2, then 3 after 64 strobes; idle 16'h50BC / charisk 01 throughout SYNC.
- Data framing: RUN, group0 = {14'h0001,14'h0002,14'h0003,14'h0004} → link0 words 0..3 = F[15:0]..F[63:48] with F[7:0]=8'hBC; link2 identical to link0.
- BC0/overflow: ttc_bx0=1 and overflow=1 → word0 low byte 8'h3C. ttc_bx0=0, overflow=1 → 8'h5C.
- Validity: cluster address 11'h600 → its valid bit 0; 11'h5FF → 1; all invalid → valid_clusters_or=0.
- Alignment: strobe at frame_cnt=1 → frame restarts, strobe_err=1. Missing strobe → idle words; strobe_err held until reset_i.
- Link loss: drop tx_ready[2] in RUN → link_state=1 and idle words on all links from the next cycle; restore → SYNC for 64 BX, then RUN.
